// File: rtl/sample_pipe_pkg.sv
// Shared defaults and helpers for the sample_pipe elastic register pipeline.
package sample_pipe_pkg;

  localparam int unsigned SAMPLE_PIPE_WIDTH_DEF = 2;
  localparam int unsigned SAMPLE_PIPE_DEPTH_DEF = 2;

  // Bits needed to count 0..depth valid stages.
  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sample_pipe_if.sv
// Upstream/downstream valid-ready bus of sample_pipe, plus the complemented payload.
interface sample_pipe_if
  import sample_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_PIPE_WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_data_n;

  // Environment side: produces upstream beats and consumes downstream beats.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_data_n
  );

  // Pipeline side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_data_n
  );

endinterface

// File: rtl/sample_pipe_stage.sv
// One elastic pipeline stage: a valid bit, a data register and its pass-through ready term.
module sample_pipe_stage #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  assign ready = !v_q || dn_ready;

  // Data only loads alongside a valid beat so idle stages do not toggle.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (ready) begin
      v_d = up_valid;
      if (up_valid) begin
        d_d = up_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign valid = v_q;
  assign data  = d_q;

endmodule

// File: rtl/sample_pipe.sv
// WIDTH-bit, DEPTH-stage elastic pipeline with true/complemented outputs.
// Define SAMPLE_PIPE_OCC_EN to add the registered occupancy output occ.
module sample_pipe
  import sample_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_PIPE_WIDTH_DEF,
  parameter int unsigned DEPTH = SAMPLE_PIPE_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  sample_pipe_if.slave               bus
`ifdef SAMPLE_PIPE_OCC_EN
  ,
  output logic [occ_w(DEPTH)-1:0]    occ
`endif
);

  logic [DEPTH-1:0] v;
  logic [DEPTH:0]   r;
  logic [WIDTH-1:0] d [DEPTH];

  assign r[DEPTH] = bus.out_ready;

  // Stage i is fed by stage i-1 (or the input port) and unblocked by stage i+1.
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_data  = bus.in_data;
    end else begin : g_body
      assign up_valid = v[i-1];
      assign up_data  = d[i-1];
    end

    sample_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_valid),
      .up_data  (up_data),
      .dn_ready (r[i+1]),
      .valid    (v[i]),
      .data     (d[i]),
      .ready    (r[i])
    );
  end

  assign bus.in_ready   = r[0];
  assign bus.out_valid  = v[DEPTH-1];
  assign bus.out_data   = d[DEPTH-1];
  assign bus.out_data_n = ~d[DEPTH-1];

`ifdef SAMPLE_PIPE_OCC_EN
  localparam int unsigned OCC_W = occ_w(DEPTH);

  logic             in_hs;
  logic             out_hs;
  logic [OCC_W-1:0] occ_q, occ_d;

  assign in_hs  = bus.in_valid && r[0];
  assign out_hs = v[DEPTH-1] && bus.out_ready;

  // Occupancy moves only when exactly one side hands a beat over.
  always_comb begin
    occ_d = occ_q;
    if (in_hs && !out_hs) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!in_hs && out_hs) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_sample_pipe.sv
// Self-checking bench for sample_pipe: directed scenarios plus a random valid/ready run.
module tb_sample_pipe;
  import sample_pipe_pkg::*;

`ifdef SAMPLE_PIPE_OCC_EN
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
`else
  localparam int unsigned WIDTH = SAMPLE_PIPE_WIDTH_DEF;
  localparam int unsigned DEPTH = SAMPLE_PIPE_DEPTH_DEF;
`endif

  logic clk = 1'b0;
  logic rst;

  sample_pipe_if #(.WIDTH(WIDTH)) bus ();

`ifdef SAMPLE_PIPE_OCC_EN
  logic [occ_w(DEPTH)-1:0] occ;
`endif

  sample_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef SAMPLE_PIPE_OCC_EN
    ,
    .occ (occ)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic last_in_hs = 1'b0;

  // Reference: FIFO of beats with the cycle each was accepted; a beat is visible at the
  // output once DEPTH cycles have passed since its acceptance and it is the oldest.
  logic [WIDTH-1:0] qd [$];
  int               qt [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check on the falling edge, then advance the model.
  task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                      input logic rv);
    logic             exp_ir, exp_ov, ihs, ohs;
    logic [WIDTH-1:0] exp_n;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    rst           = rv;
    @(negedge clk);
    exp_ir = ordy || (qd.size() < int'(DEPTH));
    exp_ov = (qd.size() > 0) && ((cyc - qt[0]) >= int'(DEPTH));
    chk("in_ready", 64'(bus.in_ready), 64'(exp_ir));
    chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    if (exp_ov) begin
      exp_n = ~qd[0];
      chk("out_data", 64'(bus.out_data), 64'(qd[0]));
      chk("out_data_n", 64'(bus.out_data_n), 64'(exp_n));
    end
`ifdef SAMPLE_PIPE_OCC_EN
    chk("occ", 64'(occ), 64'(qd.size()));
`endif
    ihs = iv && exp_ir;
    ohs = exp_ov && ordy;
    @(posedge clk);
    if (rv) begin
      qd.delete();
      qt.delete();
    end else begin
      if (ohs) begin
        void'(qd.pop_front());
        void'(qt.pop_front());
      end
      if (ihs) begin
        qd.push_back(id);
        qt.push_back(cyc);
      end
    end
    last_in_hs = ihs && !rv;
    cyc++;
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] pd;
    logic             piv;
    int               nxt;

    ones          = '1;
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = ones;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with a beat offered: nothing is captured.
    step(1'b1, ones, 1'b1, 1'b1);
    step(1'b1, ones, 1'b1, 1'b1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_data_n", 64'(bus.out_data_n), 64'(ones));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    for (int n = 0; n < int'(DEPTH) + 1; n++) step(1'b0, '0, 1'b1, 1'b0);

    // Back-to-back stream at full flow.
    for (int n = 0; n < int'(DEPTH) + 6; n++) begin
      step(n < 4, WIDTH'(n), 1'b1, 1'b0);
    end

    // Backpressure: fill past capacity, then release in FIFO order.
    nxt = 1;
    for (int n = 0; n < int'(DEPTH) + 2; n++) begin
      step(1'b1, WIDTH'(nxt), 1'b0, 1'b0);
      if (last_in_hs) nxt++;
    end
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    for (int n = 0; n < int'(DEPTH) + 4; n++) begin
      step(nxt <= int'(DEPTH) + 1, WIDTH'(nxt), 1'b1, 1'b0);
      if (last_in_hs) nxt++;
    end

    // Full pipe with both sides active: one in and one out per cycle.
    for (int n = 0; n < int'(DEPTH) + 1; n++) step(1'b1, WIDTH'(8 + n), 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) step(1'b1, WIDTH'(5 + n), 1'b1, 1'b0);
    for (int n = 0; n < int'(DEPTH) + 2; n++) step(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-flight discards every beat.
    step(1'b1, WIDTH'(2), 1'b0, 1'b0);
    step(1'b1, WIDTH'(1), 1'b0, 1'b0);
    step(1'b1, WIDTH'(3), 1'b0, 1'b1);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    for (int n = 0; n < int'(DEPTH) + 2; n++) step(1'b0, '0, 1'b1, 1'b0);

    // Random valid/ready; a presented beat stays stable until accepted.
    piv = 1'b0;
    pd  = '0;
    for (int n = 0; n < 1000; n++) begin
      if (!piv) begin
        piv = ($urandom_range(3) != 0);
        pd  = WIDTH'($urandom);
      end
      step(piv, pd, $urandom_range(2) != 0, 1'b0);
      if (last_in_hs) piv = 1'b0;
    end
    for (int n = 0; n < 2 * int'(DEPTH) + 2; n++) step(1'b0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
